// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin arbiter that gives one UART TX FIFO to NUM_REQ byte
//           sources for one whole message at a time. Define UART_ARB_TIMEOUT_EN
//           to add a stall timeout that revokes a grant that stops making progress.
// Revision: 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_available,
    output logic [7:0]           tx_data,
    input  logic                 tx_ack,
    output logic                 grant_valid,
    output logic [2:0]           grant_id,
    output logic                 timeout_abort
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] c_LAST_INIT = 3'(NUM_REQ - 1);
    localparam logic [3:0] c_NUM_REQ   = 4'(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
            $error("uart_tx_arbiter: unsupported parameter value");
        end
    endgenerate

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_grant_id;
    logic [2:0]  w_grant_id_nxt;
    logic [2:0]  r_last_grant;
    logic [2:0]  w_last_grant_nxt;
    logic [7:0]  w_valid_ext;
    logic [7:0]  w_last_ext;
    logic [63:0] w_data_ext;
    logic        w_busy;
    logic        w_xfer;
    logic        w_rr_found;
    logic [2:0]  w_rr_id;

    // Widen per-requester buses to 8 lanes so a 3-bit owner index always fits.
    assign w_valid_ext  = 8'(req_valid);
    assign w_last_ext   = 8'(req_last);
    assign w_data_ext   = 64'(req_data);

    assign w_busy       = (r_state == BUSY);
    assign tx_available = w_busy & w_valid_ext[r_grant_id];
    assign tx_data      = w_busy ? w_data_ext[{r_grant_id, 3'b000} +: 8] : 8'h00;
    assign w_xfer       = tx_available & tx_ack;
    assign grant_valid  = w_busy;
    assign grant_id     = r_grant_id;

    always_comb begin
        req_ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i] = w_busy & tx_ack & (r_grant_id == 3'(i));
        end
    end

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        logic [3:0] w_cand;
        w_cand     = '0;
        w_rr_found = 1'b0;
        w_rr_id    = r_last_grant;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = {1'b0, r_last_grant} + 4'(i);
            if (w_cand >= c_NUM_REQ) begin
                w_cand = w_cand - c_NUM_REQ;
            end
            if (!w_rr_found && w_valid_ext[w_cand[2:0]]) begin
                w_rr_found = 1'b1;
                w_rr_id    = w_cand[2:0];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_STALL_W = $clog2(TIMEOUT_CYCLES);

    logic [c_STALL_W-1:0] r_stall;
    logic [c_STALL_W-1:0] w_stall_nxt;
    logic                 w_stall_hit;
    logic                 r_abort;
    logic                 w_abort_nxt;

    assign w_stall_hit   = (r_stall == c_STALL_W'(TIMEOUT_CYCLES - 1));
    assign timeout_abort = r_abort;

    // Counter is zero in IDLE, so it is already clear on entry to BUSY.
    always_comb begin
        w_stall_nxt = '0;
        if (w_busy && !w_xfer && !w_stall_hit) begin
            w_stall_nxt = r_stall + c_STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
            r_abort <= 1'b0;
        end else begin
            r_stall <= w_stall_nxt;
            r_abort <= w_abort_nxt;
        end
    end
`else
    assign timeout_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
`ifdef UART_ARB_TIMEOUT_EN
        w_abort_nxt      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_rr_found) begin
                    w_state_nxt    = BUSY;
                    w_grant_id_nxt = w_rr_id;
                end
            end
            BUSY: begin
                if (w_xfer && w_last_ext[r_grant_id]) begin
                    w_state_nxt      = IDLE;
                    w_last_grant_nxt = r_grant_id;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (!w_xfer && w_stall_hit) begin
                    w_state_nxt      = IDLE;
                    w_last_grant_nxt = r_grant_id;
                    w_abort_nxt      = 1'b1;
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= c_LAST_INIT;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic, checked
// against a message-level reference model of uart_tx_arbiter.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 16;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit c_TMO_EN = 1'b1;
`else
    localparam bit c_TMO_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tx_available;
    logic [7:0]           tx_data;
    logic                 tx_ack;
    logic                 grant_valid;
    logic [2:0]           grant_id;
    logic                 timeout_abort;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ack      (req_ack),
        .tx_available (tx_available),
        .tx_data      (tx_data),
        .tx_ack       (tx_ack),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .timeout_abort(timeout_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Pending message bytes per requester
    logic [7:0] q_data[NUM_REQ][$];
    bit         q_last[NUM_REQ][$];

    bit [NUM_REQ-1:0] off;
    int vprob, aprob;
    bit ack_low;

    // Reference model: who owns the UART, who owned it last, idle-progress count
    bit m_busy;
    int m_owner, m_last, m_stall, m_xfers;
    bit m_abort;

    // Observations of the DUT
    int g_id[$];
    int g_cyc[$];
    int x_log[$];
    bit prev_gv;
    int n_abort, abort_cyc, obs_xfers, xfer_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_msg(input int r, input int len, input int base);
        for (int k = 0; k < len; k++) begin
            q_data[r].push_back(8'(base + k));
            q_last[r].push_back(k == len - 1);
        end
    endtask

    task automatic clear_logs();
        g_id.delete();
        g_cyc.delete();
        x_log.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m_busy = 0; m_owner = 0; m_last = NUM_REQ - 1; m_stall = 0; m_abort = 0;
        for (int r = 0; r < NUM_REQ; r++) begin
            q_data[r].delete();
            q_last[r].delete();
        end
        req_valid = '0; req_data = '0; req_last = '0; tx_ack = 1'b0;
        prev_gv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_grant_valid", grant_valid, 0);
        check_eq("rst_grant_id", grant_id, 0);
        check_eq("rst_timeout_abort", timeout_abort, 0);
        check_eq("rst_tx_available", tx_available, 0);
        check_eq("rst_req_ack", req_ack, 0);
        rst_n = 1'b1;
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] exp_ack;
        bit exp_av, xfer, is_last;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (q_data[i].size() > 0 && !off[i] && $urandom_range(99) < vprob) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = q_data[i][0];
                req_last[i]        = q_last[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
        exp_av = m_busy && req_valid[m_owner];
        tx_ack = exp_av && !ack_low && ($urandom_range(99) < aprob);
        @(negedge clk);
        cyc++;
        exp_ack = '0;
        if (m_busy && tx_ack) exp_ack[m_owner] = 1'b1;
        check_eq("grant_valid", grant_valid, m_busy);
        check_eq("grant_id", grant_id, m_owner);
        check_eq("tx_available", tx_available, exp_av);
        if (exp_av) check_eq("tx_data", tx_data, req_data[8*m_owner +: 8]);
        check_eq("req_ack", req_ack, exp_ack);
        check_eq("timeout_abort", timeout_abort, m_abort);

        if (grant_valid && !prev_gv) begin
            g_id.push_back(int'(grant_id));
            g_cyc.push_back(cyc);
        end
        prev_gv = grant_valid;
        if (tx_available && tx_ack) begin
            x_log.push_back(int'(grant_id) * 256 + int'(tx_data));
            obs_xfers++;
        end
        if (timeout_abort) begin
            n_abort++;
            abort_cyc = cyc;
        end

        xfer    = exp_av && tx_ack;
        m_abort = 0;
        if (!m_busy) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!m_busy && req_valid[(m_last + k) % NUM_REQ]) begin
                    m_busy  = 1;
                    m_owner = (m_last + k) % NUM_REQ;
                end
            end
            m_stall = 0;
        end else begin
            is_last = 0;
            if (xfer) begin
                is_last = q_last[m_owner][0];
                void'(q_data[m_owner].pop_front());
                void'(q_last[m_owner].pop_front());
                m_xfers++;
            end
            if (xfer && is_last) begin
                m_busy = 0;
                m_last = m_owner;
            end else if (c_TMO_EN && !xfer && m_stall == TIMEOUT_CYCLES - 1) begin
                m_busy  = 0;
                m_last  = m_owner;
                m_abort = 1;
            end else begin
                m_stall = xfer ? 0 : m_stall + 1;
            end
        end
    endtask

    initial begin
        int exp_id, exp_byte;
        vprob = 100; aprob = 100; ack_low = 0; off = '0;
        n_abort = 0; abort_cyc = -1; obs_xfers = 0; m_xfers = 0;
        apply_reset();

        // All four request 2-byte messages; requester 0 has a second one queued.
        for (int r = 0; r < NUM_REQ; r++) push_msg(r, 2, 8'h10 * r);
        push_msg(0, 2, 8'hE0);
        clear_logs();
        repeat (20) step();
        check_eq("rr_count", g_id.size(), 5);
        for (int k = 0; k < 5 && k < g_id.size(); k++) check_eq("rr_order", g_id[k], k % NUM_REQ);
        for (int k = 1; k < 5 && k < g_cyc.size(); k++) check_eq("rr_gap", g_cyc[k] - g_cyc[k-1], 3);
        check_eq("rr_bytes", x_log.size(), 10);
        for (int k = 0; k < 10 && k < x_log.size(); k++) begin
            exp_id   = (k / 2) % NUM_REQ;
            exp_byte = (k >= 8) ? 8'hE0 + (k % 2) : 8'h10 * exp_id + (k % 2);
            check_eq("rr_stream", x_log[k], exp_id * 256 + exp_byte);
        end

        // Requester 2 owns a 3-byte message, UART back-pressures, requester 1 waits.
        clear_logs();
        push_msg(2, 3, 8'h41);
        step();
        push_msg(1, 1, 8'h11);
        step();
        ack_low = 1;
        repeat (5) step();
        ack_low = 0;
        repeat (8) step();
        check_eq("bp_bytes", x_log.size(), 4);
        for (int k = 0; k < 4 && k < x_log.size(); k++)
            check_eq("bp_stream", x_log[k], (k < 3) ? (2 * 256 + 8'h41 + k) : (1 * 256 + 8'h11));
        check_eq("bp_grants", g_id.size(), 2);
        for (int k = 0; k < 2 && k < g_id.size(); k++) check_eq("bp_order", g_id[k], (k == 0) ? 2 : 1);

        // Single-byte message from requester 0.
        clear_logs();
        push_msg(0, 1, 8'h55);
        repeat (6) step();
        check_eq("single_bytes", x_log.size(), 1);
        if (x_log.size() > 0) check_eq("single_byte", x_log[0], 8'h55);
        check_eq("single_grants", g_id.size(), 1);
        check_eq("single_idle", grant_valid, 0);

        // Reset lands during the second byte of a 4-byte message from requester 3.
        clear_logs();
        push_msg(3, 4, 8'hA0);
        step();
        step();
        @(posedge clk);
        #1;
        req_data[8*3 +: 8] = q_data[3][0];
        req_last[3]        = q_last[3][0];
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_gv", grant_valid, 0);
        check_eq("async_rst_id", grant_id, 0);
        check_eq("pre_rst_bytes", x_log.size(), 1);
        if (x_log.size() > 0) check_eq("pre_rst_byte", x_log[0], 3 * 256 + 8'hA0);
        apply_reset();
        clear_logs();
        push_msg(1, 1, 8'h61);
        push_msg(0, 1, 8'h60);
        push_msg(2, 1, 8'h62);
        repeat (8) step();
        check_eq("post_rst_grants", g_id.size(), 3);
        for (int k = 0; k < 3 && k < g_id.size(); k++) check_eq("post_rst_order", g_id[k], k);

        // Granted requester 1 stops offering bytes mid-message.
        clear_logs();
        n_abort = 0;
        push_msg(1, 4, 8'hC0);
        step();
        push_msg(2, 1, 8'hD0);
        step();
        xfer_cyc = cyc;
        off[1] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
        for (int k = 0; k < 40 && n_abort == 0; k++) step();
        check_eq("tmo_seen", n_abort, 1);
        check_eq("tmo_delay", abort_cyc - xfer_cyc, 17);
        repeat (3) step();
        check_eq("tmo_grants", g_id.size(), 2);
        if (g_id.size() == 2) begin
            check_eq("tmo_next_id", g_id[1], 2);
            check_eq("tmo_next_cyc", g_cyc[1], abort_cyc + 1);
        end
`else
        repeat (1000) step();
        check_eq("hold_gv", grant_valid, 1);
        check_eq("hold_id", grant_id, 1);
        check_eq("hold_no_abort", n_abort, 0);
        check_eq("hold_grants", g_id.size(), 1);
`endif
        off = '0;

        // Randomized traffic
        apply_reset();
        vprob = 75; aprob = 70;
        m_xfers = 0; obs_xfers = 0;
        repeat (800) begin
            for (int r = 0; r < NUM_REQ; r++)
                if (q_data[r].size() == 0 && $urandom_range(99) < 30)
                    push_msg(r, $urandom_range(4, 1), $urandom_range(255));
            step();
        end
        check_eq("rand_xfer_count", obs_xfers, m_xfers);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
